// File: rtl/op_frame_rx.sv
// op_frame_rx: symbol-serial operation receiver that hunts SYNC_SYM, assembles A/B/C/OP into a valid/ready register.
// Define OP_FRAME_RX_CHECKSUM_EN to require a trailing XOR checksum symbol after the payload.
module op_frame_rx #(
    parameter int               SYM_W    = 4,
    parameter int               A_W      = 4,
    parameter int               B_W      = 4,
    parameter int               C_W      = 8,
    parameter int               OP_W     = 4,
    parameter logic [SYM_W-1:0] SYNC_SYM = 'hA,
    parameter int               TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_data_valid_i,
    input  logic [SYM_W-1:0] rd_data_i,
    output logic [A_W-1:0]   op_a_o,
    output logic [B_W-1:0]   op_b_o,
    output logic [C_W-1:0]   op_c_o,
    output logic [OP_W-1:0]  op_op_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic [1:0]       err_code_o
);
    // state | meaning
    // IDLE  | hunting for SYNC_SYM, other symbols discarded
    // RECV  | shifting payload symbols into shreg
    // CHK   | waiting for the checksum symbol (checksum build only)

    localparam int PAY_W = A_W + B_W + C_W + OP_W;
    localparam int N_SYM = PAY_W / SYM_W;
    localparam int CNT_W = $clog2(N_SYM + 1);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(N_SYM - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

`ifdef OP_FRAME_RX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, RECV, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] sym_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [PAY_W-1:0] shreg;
    logic [PAY_W-1:0] next_word;
    logic [PAY_W-1:0] commit_word;
    logic             timed_out;
    logic             frame_end;
    logic             csum_bad;
`ifdef OP_FRAME_RX_CHECKSUM_EN
    logic [SYM_W-1:0] csum;
`endif

    assign busy_o    = (state != IDLE);
    assign next_word = {shreg[PAY_W-SYM_W-1:0], rd_data_i};
    assign timed_out = (TIMEOUT != 0) && (state != IDLE) && (to_cnt == TO_MAX);

    // frame_end marks the cycle the last symbol of a frame is accepted
`ifdef OP_FRAME_RX_CHECKSUM_EN
    assign frame_end   = (state == CHK) && rd_data_valid_i && !timed_out;
    assign csum_bad    = (rd_data_i != csum);
    assign commit_word = shreg;
`else
    assign frame_end   = (state == RECV) && rd_data_valid_i && !timed_out && (sym_cnt == LAST_SYM);
    assign csum_bad    = 1'b0;
    assign commit_word = next_word;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sym_cnt     <= '0;
            to_cnt      <= '0;
            shreg       <= '0;
            op_a_o      <= '0;
            op_b_o      <= '0;
            op_c_o      <= '0;
            op_op_o     <= '0;
            op_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= 2'b00;
`ifdef OP_FRAME_RX_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            if (op_valid_o && op_ready_i)
                op_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_data_valid_i && rd_data_i == SYNC_SYM) begin
                        state   <= RECV;
                        sym_cnt <= '0;
                        to_cnt  <= '0;
`ifdef OP_FRAME_RX_CHECKSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                RECV: begin
                    if (timed_out) begin
                        state       <= IDLE;
                        frame_err_o <= 1'b1;
                        err_code_o  <= 2'b01;
                    end else if (rd_data_valid_i) begin
                        to_cnt  <= '0;
                        shreg   <= next_word;
                        sym_cnt <= sym_cnt + CNT_W'(1);
`ifdef OP_FRAME_RX_CHECKSUM_EN
                        csum    <= csum ^ rd_data_i;
                        if (sym_cnt == LAST_SYM)
                            state <= CHK;
`else
                        if (sym_cnt == LAST_SYM)
                            state <= IDLE;
`endif
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
`ifdef OP_FRAME_RX_CHECKSUM_EN
                CHK: begin
                    if (timed_out) begin
                        state       <= IDLE;
                        frame_err_o <= 1'b1;
                        err_code_o  <= 2'b01;
                    end else if (rd_data_valid_i) begin
                        state <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            // a frame lands only if the output register is free or draining this cycle
            if (frame_end) begin
                if (csum_bad) begin
                    frame_err_o <= 1'b1;
                    err_code_o  <= 2'b11;
                end else if (!op_valid_o || op_ready_i) begin
                    op_a_o     <= commit_word[PAY_W-1 -: A_W];
                    op_b_o     <= commit_word[PAY_W-A_W-1 -: B_W];
                    op_c_o     <= commit_word[C_W+OP_W-1 -: C_W];
                    op_op_o    <= commit_word[OP_W-1:0];
                    op_valid_o <= 1'b1;
                end else begin
                    frame_err_o <= 1'b1;
                    err_code_o  <= 2'b10;
                end
            end
        end
    end
endmodule
